router_fifo: RTL and testbench
==============================

Name: router_fifo

Overview:
- Output-side packet FIFO of the 1x3 router; three instances sit directly downstream of the synchronizer.
- Each instance takes one write enable bit, its soft reset and the shared input data bus.
- Stores header, payload and parity bytes, tagging the header byte with a load-first-data flag.
- Feeds the destination read port and reports full/empty; the synchronizer turns these into fifofull and vldout.

Parameters:
- WIDTH, 8, data byte width.
- DEPTH, 16, number of entries (power of 2).
- AW, 4, address width = log2(DEPTH).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- softrst  input  1  synchronous soft reset from synchronizer, active-high (read-timeout flush).
- wren  input  1  write enable for this FIFO.
- reen  input  1  read enable from destination.
- lfd  input  1  marks current din as packet header byte.
- din  input  WIDTH  data byte in.
- dout  output  WIDTH  registered read data.
- full  output  1  FIFO holds DEPTH entries.
- empty  output  1  FIFO holds 0 entries.

Behaviour:
- Storage: DEPTH x (WIDTH+1); bit WIDTH holds the lfd tag. Memory contents are not reset.
- Pointers: wr_ptr and rd_ptr are AW+1 bits wide, with the MSB used as a wrap bit. Both wrap naturally modulo 2*DEPTH.
- empty = (wr_ptr == rd_ptr); combinational from registers.
- full = low AW bits equal and MSBs differ; combinational from registers.
- Reset priority: rst > softrst > normal operation.
- rst or softrst clears wr_ptr, rd_ptr and pkt_cnt to 0 and dout to 0, so full=0 and empty=1 on the next cycle. Any same-cycle wren or reen is ignored.
- Write: when wren && !full, mem[wr_ptr[AW-1:0]] <= {lfd, din} and wr_ptr += 1. wren while full is dropped silently with no pointer change.
- Read: when reen && !empty, dout <= mem[rd_ptr][WIDTH-1:0] and rd_ptr += 1.
  - Read latency is 1 clock: data appears on dout the cycle after reen is sampled.
- Packet counter pkt_cnt (6 bits):
  - On a read of a tagged entry: pkt_cnt <= entry[7:2] + 1 (payload length plus parity byte).
  - On a read of an untagged entry with pkt_cnt != 0: pkt_cnt -= 1.
  - pkt_cnt never underflows; it saturates at 0.
- dout hold/clear:
  - With no read, dout holds its value while pkt_cnt != 0.
  - When pkt_cnt == 0 and no read occurs, dout <= 0. The parity byte therefore stays visible for exactly 1 cycle after it is read, then dout returns to 0.
- Simultaneous wren and reen:
  - Not full and not empty: both proceed; occupancy is unchanged.
  - Full: the read proceeds and the write is dropped; full is evaluated on pre-edge state.
  - Empty: the write proceeds and the read is ignored, so dout follows the hold/clear rule above.
- Wrap-around: pointers pass index DEPTH-1 to 0 with the MSB toggling. Data order is preserved across the wrap.
- softrst mid-packet discards all queued bytes and zeroes pkt_cnt. A subsequent write starts a clean packet.
- Header with length 0: pkt_cnt <= 1, so exactly one more byte (parity) is counted.

Test Plan:
- Reset:
  - Stimulus: rst=1 for 2 cycles with wren=1, din=8'hAA.
  - Required: empty=1, full=0, dout=0; no entry written (empty still 1 after rst drops with wren=0).
- Single packet:
  - Stimulus: write header 8'h0C with lfd=1 (length 3), payload 11,22,33, parity 5A, then reen=1 for 5 cycles.
  - Required: dout = 0C,11,22,33,5A on consecutive cycles, 1 cycle after each reen.
  - Required: empty=1 after the 5th read; dout=0 the cycle after 5A.
- Fill and overflow:
  - Stimulus: 17 writes of values 0..16 with no reads.
  - Required: full=1 after the 16th write; the 17th (16) is dropped; 16 reads return 0..15, then empty=1.
- Simultaneous read and write:
  - Full: reen=wren=1 with din=8'h77 for 1 cycle; rd_ptr advances, the write is dropped, full drops to 0.
  - Half-full: reen=wren=1 for 4 cycles; occupancy is unchanged.
- Soft reset mid-packet:
  - Stimulus: 6 bytes written, 2 read, then softrst=1 for 1 cycle.
  - Required: empty=1 and dout=0 next cycle; a new header 8'h04 written afterwards reads back correctly.
- Wrap-around:
  - Stimulus: 3 rounds of 10 writes followed by 10 reads.
  - Required: data order preserved, full never asserted, empty=1 after each round.

Source files
------------

// File: rtl/router_fifo.sv
// Output-side packet FIFO of the 1x3 router.
// Header bytes are tagged so the reader can track packet length.
module router_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             softrst,
  input  logic             wren,
  input  logic             reen,
  input  logic             lfd,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  logic [WIDTH:0]   mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [5:0]       pkt_cnt_q, pkt_cnt_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [WIDTH:0]   rd_entry;
  logic             do_wr;
  logic             do_rd;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                 (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign dout  = dout_q;

  assign rd_entry = mem_q[rd_ptr_q[AW-1:0]];
  assign do_wr    = wren && !full && !softrst;
  assign do_rd    = reen && !empty && !softrst;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    pkt_cnt_d = pkt_cnt_q;
    dout_d    = dout_q;
    if (softrst) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      pkt_cnt_d = '0;
      dout_d    = '0;
    end else begin
      if (do_wr)
        wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_rd) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        dout_d   = rd_entry[WIDTH-1:0];
        // header carries payload length in bits 7:2; +1 covers parity
        if (rd_entry[WIDTH])
          pkt_cnt_d = rd_entry[7:2] + 6'd1;
        else if (pkt_cnt_q != 6'd0)
          pkt_cnt_d = pkt_cnt_q - 6'd1;
      end else if (pkt_cnt_q == 6'd0) begin
        dout_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      pkt_cnt_q <= '0;
      dout_q    <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      pkt_cnt_q <= pkt_cnt_d;
      dout_q    <= dout_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && do_wr)
      mem_q[wr_ptr_q[AW-1:0]] <= {lfd, din};
  end

endmodule

// File: tb/tb_router_fifo.sv
// Directed self-checking bench for router_fifo.
// Inputs change 1ns after the rising edge; outputs are checked there too.
module tb_router_fifo;

  logic       clk;
  logic       rst;
  logic       softrst;
  logic       wren;
  logic       reen;
  logic       lfd;
  logic [7:0] din;
  logic [7:0] dout;
  logic       full;
  logic       empty;

  int total;
  int bad;

  router_fifo #(.WIDTH(8), .DEPTH(16), .AW(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .softrst (softrst),
    .wren    (wren),
    .reen    (reen),
    .lfd     (lfd),
    .din     (din),
    .dout    (dout),
    .full    (full),
    .empty   (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wren = 1'b0;
    reen = 1'b0;
    lfd  = 1'b0;
  endtask

  task automatic wr(input logic l, input logic [7:0] d);
    wren = 1'b1;
    reen = 1'b0;
    lfd  = l;
    din  = d;
    step();
    idle();
  endtask

  task automatic test_reset();
    rst = 1'b1; softrst = 1'b0;
    reen = 1'b0; lfd = 1'b0;
    wren = 1'b1; din = 8'hAA;
    step(); step();
    total++;
    if (empty !== 1'b1) begin
      bad++; $display("FAIL rst_empty got=%b exp=1", empty);
    end
    total++;
    if (full !== 1'b0) begin
      bad++; $display("FAIL rst_full got=%b exp=0", full);
    end
    total++;
    if (dout !== 8'h00) begin
      bad++; $display("FAIL rst_dout got=%h exp=00", dout);
    end
    rst = 1'b0;
    idle();
    step();
    total++;
    if (empty !== 1'b1) begin
      bad++; $display("FAIL rst_nowrite got=%b exp=1", empty);
    end
  endtask

  task automatic test_single_packet();
    logic [7:0] exp [5];
    exp[0] = 8'h0C; exp[1] = 8'h11; exp[2] = 8'h22;
    exp[3] = 8'h33; exp[4] = 8'h5A;
    for (int i = 0; i < 5; i++) wr(i == 0, exp[i]);
    reen = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if (dout !== exp[i]) begin
        bad++; $display("FAIL pkt_dout%0d got=%h exp=%h", i, dout, exp[i]);
      end
    end
    total++;
    if (empty !== 1'b1) begin
      bad++; $display("FAIL pkt_empty got=%b exp=1", empty);
    end
    idle();
    step();
    total++;
    if (dout !== 8'h00) begin
      bad++; $display("FAIL pkt_clear got=%h exp=00", dout);
    end
  endtask

  task automatic test_hold();
    wr(1'b1, 8'h08);
    wr(1'b0, 8'hA1);
    wr(1'b0, 8'hA2);
    wr(1'b0, 8'hC3);
    reen = 1'b1;
    step();
    idle();
    for (int i = 0; i < 2; i++) begin
      step();
      total++;
      if (dout !== 8'h08) begin
        bad++; $display("FAIL hold%0d got=%h exp=08", i, dout);
      end
    end
    reen = 1'b1;
    step(); step(); step();
    total++;
    if (dout !== 8'hC3) begin
      bad++; $display("FAIL hold_parity got=%h exp=c3", dout);
    end
    idle();
    step();
    total++;
    if (dout !== 8'h00) begin
      bad++; $display("FAIL hold_clear got=%h exp=00", dout);
    end
  endtask

  task automatic test_zero_len();
    wr(1'b1, 8'h01);
    wr(1'b0, 8'h5B);
    wr(1'b0, 8'h77);
    reen = 1'b1;
    step(); step();
    total++;
    if (dout !== 8'h5B) begin
      bad++; $display("FAIL zl_parity got=%h exp=5b", dout);
    end
    idle();
    step();
    total++;
    if (dout !== 8'h00) begin
      bad++; $display("FAIL zl_clear got=%h exp=00", dout);
    end
    reen = 1'b1;
    step();
    idle();
    step();
    total++;
    if (dout !== 8'h00 || empty !== 1'b1) begin
      bad++; $display("FAIL zl_stray got=%h/%b exp=00/1", dout, empty);
    end
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i < 17; i++) begin
      wr(1'b0, 8'(i));
      if (i == 15) begin
        total++;
        if (full !== 1'b1) begin
          bad++; $display("FAIL fill_full got=%b exp=1", full);
        end
      end
    end
    total++;
    if (full !== 1'b1 || empty !== 1'b0) begin
      bad++; $display("FAIL ovf_flags got=%b%b exp=10", full, empty);
    end
    reen = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      total++;
      if (dout !== 8'(i)) begin
        bad++; $display("FAIL fill_rd%0d got=%h exp=%h", i, dout, 8'(i));
      end
    end
    idle();
    total++;
    if (empty !== 1'b1) begin
      bad++; $display("FAIL fill_empty got=%b exp=1", empty);
    end
  endtask

  task automatic test_simultaneous();
    logic [7:0] exp [12];
    for (int i = 0; i < 16; i++) wr(1'b0, 8'(i));
    wren = 1'b1; reen = 1'b1; din = 8'h77;
    step();
    idle();
    total++;
    if (full !== 1'b0 || dout !== 8'h00) begin
      bad++; $display("FAIL sim_full got=%b/%h exp=0/00", full, dout);
    end
    reen = 1'b1;
    for (int i = 0; i < 7; i++) step();
    total++;
    if (dout !== 8'h07) begin
      bad++; $display("FAIL sim_pre got=%h exp=07", dout);
    end
    for (int i = 0; i < 4; i++) begin
      wren = 1'b1; reen = 1'b1; din = 8'hA0 + 8'(i);
      step();
      total++;
      if (dout !== 8'h08 + 8'(i) || full !== 1'b0 || empty !== 1'b0) begin
        bad++;
        $display("FAIL sim_half%0d got=%h/%b%b exp=%h/00",
                 i, dout, full, empty, 8'h08 + 8'(i));
      end
    end
    idle();
    for (int i = 0; i < 4; i++) exp[i] = 8'h0C + 8'(i);
    for (int i = 0; i < 4; i++) exp[4+i] = 8'hA0 + 8'(i);
    reen = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      total++;
      if (dout !== exp[i]) begin
        bad++; $display("FAIL sim_drain%0d got=%h exp=%h", i, dout, exp[i]);
      end
    end
    idle();
    total++;
    if (empty !== 1'b1) begin
      bad++; $display("FAIL sim_empty got=%b exp=1", empty);
    end
    step();
  endtask

  task automatic test_softrst();
    wr(1'b1, 8'h10);
    for (int i = 0; i < 5; i++) wr(1'b0, 8'hD0 + 8'(i));
    reen = 1'b1;
    step(); step();
    total++;
    if (dout !== 8'hD0) begin
      bad++; $display("FAIL srst_pre got=%h exp=d0", dout);
    end
    idle();
    softrst = 1'b1; wren = 1'b1; reen = 1'b1; din = 8'hEE;
    step();
    softrst = 1'b0;
    idle();
    total++;
    if (empty !== 1'b1 || full !== 1'b0 || dout !== 8'h00) begin
      bad++;
      $display("FAIL srst_flush got=%b%b/%h exp=10/00", empty, full, dout);
    end
    wr(1'b1, 8'h04);
    wr(1'b0, 8'hBE);
    wr(1'b0, 8'hEF);
    reen = 1'b1;
    step();
    total++;
    if (dout !== 8'h04) begin
      bad++; $display("FAIL srst_hdr got=%h exp=04", dout);
    end
    step(); step();
    total++;
    if (dout !== 8'hEF || empty !== 1'b1) begin
      bad++; $display("FAIL srst_par got=%h/%b exp=ef/1", dout, empty);
    end
    idle();
    step();
    total++;
    if (dout !== 8'h00) begin
      bad++; $display("FAIL srst_clear got=%h exp=00", dout);
    end
  endtask

  task automatic test_wrap();
    logic saw_full;
    for (int r = 0; r < 3; r++) begin
      saw_full = 1'b0;
      for (int i = 0; i < 10; i++) begin
        wr(1'b0, 8'(r * 16 + i));
        if (full) saw_full = 1'b1;
      end
      reen = 1'b1;
      for (int i = 0; i < 10; i++) begin
        step();
        total++;
        if (dout !== 8'(r * 16 + i)) begin
          bad++;
          $display("FAIL wrap%0d_%0d got=%h exp=%h",
                   r, i, dout, 8'(r * 16 + i));
        end
      end
      idle();
      total++;
      if (empty !== 1'b1 || saw_full !== 1'b0) begin
        bad++;
        $display("FAIL wrap%0d_flags empty=%b full_seen=%b exp=1/0",
                 r, empty, saw_full);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1; softrst = 1'b0;
    wren = 1'b0; reen = 1'b0; lfd = 1'b0; din = 8'h00;
    test_reset();
    test_single_packet();
    test_hold();
    test_zero_len();
    test_fill_overflow();
    test_simultaneous();
    test_softrst();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
